// File: rtl/chunked_comparator_pkg.sv
// rtl/chunked_comparator_pkg.sv - shared encodings and helpers for the chunked branch comparator
// Purpose: branch funct3 encodings, FSM state enumeration, and the
//          branch-condition decode shared by the comparator slice.
// Ports:   none (package)
package chunked_comparator_pkg;

   localparam logic [2:0] FUNC_BEQ  = 3'b000;
   localparam logic [2:0] FUNC_BNE  = 3'b001;
   localparam logic [2:0] FUNC_BLT  = 3'b100;
   localparam logic [2:0] FUNC_BGE  = 3'b101;
   localparam logic [2:0] FUNC_BLTU = 3'b110;
   localparam logic [2:0] FUNC_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // 010 and 011 carry no branch meaning.
   function automatic logic func_illegal(input logic [2:0] func);
      return (func == 3'b010) || (func == 3'b011);
   endfunction

   function automatic logic branch_taken(input logic [2:0] func,
                                         input logic       eq,
                                         input logic       lt);
      logic t;
      t = 1'b0;
      case (func)
         FUNC_BEQ:  t = eq;
         FUNC_BNE:  t = !eq;
         FUNC_BLT:  t = lt;
         FUNC_BGE:  t = !lt;
         FUNC_BLTU: t = lt;
         FUNC_BGEU: t = !lt;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/chunked_comparator_chunk_compare.sv
// rtl/chunked_comparator_chunk_compare.sv - combinational compare of one operand chunk
// Purpose: compares two CHUNK-bit slices; in signed mode the sign bits are
//          inverted so that an unsigned compare yields the two's-complement order.
// Ports:   a, b        - chunk slices of operand A and B
//          signed_mode - treat the slices as the signed top chunk
//          eq          - a == b
//          lt          - a < b (signed when signed_mode, else unsigned)
module chunk_compare #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             signed_mode,
   output logic             eq,
   output logic             lt
);

   logic [CHUNK-1:0] flip;
   logic [CHUNK-1:0] a_adj;
   logic [CHUNK-1:0] b_adj;

   assign flip  = CHUNK'(signed_mode) << (CHUNK - 1);
   assign a_adj = a ^ flip;
   assign b_adj = b ^ flip;
   assign eq    = (a == b);
   assign lt    = (a_adj < b_adj);

endmodule

// File: rtl/chunked_comparator.sv
// rtl/chunked_comparator.sv - multi-cycle branch comparator scanning CHUNK bits per cycle
// Purpose: captures two operands and a branch funct3, compares them one chunk
//          per cycle from the most-significant end with early exit on the
//          first differing chunk, and holds eq/lt/taken/illegal until consumed.
// Ports:   clk, reset_n            - clock, asynchronous active-low reset
//          in_valid, in_ready      - request handshake (ready only when idle)
//          rs1d, rs2d, func        - operands A, B and branch funct3
//          out_valid, out_ready    - result handshake
//          eq, lt, taken, illegal  - registered result
module chunked_comparator #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] rs1d,
   input  logic [WIDTH-1:0] rs2d,
   input  logic [2:0]       func,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             lt,
   output logic             taken,
   output logic             illegal
);

   import chunked_comparator_pkg::*;

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       func_q;
   logic [IDXW-1:0]  idx_q;
   logic             eq_q;
   logic             lt_q;
   logic             taken_q;
   logic             illegal_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic             c_signed;
   logic             c_eq;
   logic             c_lt;

   assign a_chunk  = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign b_chunk  = b_q[int'(idx_q) * CHUNK +: CHUNK];
   // Only the top chunk carries the sign; func[1]=1 covers unsigned and illegal codes.
   assign c_signed = (idx_q == TOP_IDX) && !func_q[1];

   chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
      .a           (a_chunk),
      .b           (b_chunk),
      .signed_mode (c_signed),
      .eq          (c_eq),
      .lt          (c_lt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (!c_eq || (idx_q == '0)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q       <= '0;
         b_q       <= '0;
         func_q    <= '0;
         idx_q     <= '0;
         eq_q      <= 1'b0;
         lt_q      <= 1'b0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q    <= rs1d;
                  b_q    <= rs2d;
                  func_q <= func;
                  idx_q  <= TOP_IDX;
               end
            end
            ST_SCAN: begin
               if (!c_eq) begin
                  eq_q      <= 1'b0;
                  lt_q      <= c_lt;
                  taken_q   <= branch_taken(func_q, 1'b0, c_lt);
                  illegal_q <= func_illegal(func_q);
               end else if (idx_q == '0) begin
                  eq_q      <= 1'b1;
                  lt_q      <= 1'b0;
                  taken_q   <= branch_taken(func_q, 1'b1, 1'b0);
                  illegal_q <= func_illegal(func_q);
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign eq      = eq_q;
   assign lt      = lt_q;
   assign taken   = taken_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_chunked_comparator.sv
// tb/tb_chunked_comparator.sv - directed self-checking bench for chunked_comparator
module tb_chunked_comparator;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rs1d;
   logic [31:0] rs2d;
   logic [2:0]  func;
   logic        out_valid;
   logic        out_ready;
   logic        eq;
   logic        lt;
   logic        taken;
   logic        illegal;

   int tests_run;
   int tests_failed;

   chunked_comparator #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs1d      (rs1d),
      .rs2d      (rs2d),
      .func      (func),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eq        (eq),
      .lt        (lt),
      .taken     (taken),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one request and returns edges from accept until out_valid (scan cycles + 1).
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, output int lat);
      in_valid = 1'b1;
      rs1d     = a;
      rs2d     = b;
      func     = f;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      tests_run++; if (eq !== 1'b0) begin tests_failed++; $display("FAIL reset_eq got %b want 0", eq); end
      tests_run++; if (lt !== 1'b0) begin tests_failed++; $display("FAIL reset_lt got %b want 0", lt); end
      tests_run++; if (taken !== 1'b0) begin tests_failed++; $display("FAIL reset_taken got %b want 0", taken); end
      tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal got %b want 0", illegal); end
      reset_n = 1'b1;
   endtask

   task automatic test_beq_equal();
      int lat;
      issue(32'h1234_5678, 32'h1234_5678, 3'b000, lat);
      tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL beq_latency got %0d want 5", lat); end
      tests_run++; if (eq !== 1'b1) begin tests_failed++; $display("FAIL beq_eq got %b want 1", eq); end
      tests_run++; if (lt !== 1'b0) begin tests_failed++; $display("FAIL beq_lt got %b want 0", lt); end
      tests_run++; if (taken !== 1'b1) begin tests_failed++; $display("FAIL beq_taken got %b want 1", taken); end
      tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL beq_illegal got %b want 0", illegal); end
      ack();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL beq_ack_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_signed_unsigned();
      int lat;
      issue(32'h8000_0000, 32'h0000_0001, 3'b100, lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL blt_latency got %0d want 2", lat); end
      tests_run++; if (lt !== 1'b1) begin tests_failed++; $display("FAIL blt_lt got %b want 1", lt); end
      tests_run++; if (eq !== 1'b0) begin tests_failed++; $display("FAIL blt_eq got %b want 0", eq); end
      tests_run++; if (taken !== 1'b1) begin tests_failed++; $display("FAIL blt_taken got %b want 1", taken); end
      ack();
      issue(32'h8000_0000, 32'h0000_0001, 3'b110, lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL bltu_latency got %0d want 2", lat); end
      tests_run++; if (lt !== 1'b0) begin tests_failed++; $display("FAIL bltu_lt got %b want 0", lt); end
      tests_run++; if (taken !== 1'b0) begin tests_failed++; $display("FAIL bltu_taken got %b want 0", taken); end
      ack();
      // Both negative: top chunks equal, decided in the lowest chunk.
      issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b100, lat);
      tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL blt_neg_latency got %0d want 5", lat); end
      tests_run++; if (lt !== 1'b1) begin tests_failed++; $display("FAIL blt_neg_lt got %b want 1", lt); end
      tests_run++; if (taken !== 1'b1) begin tests_failed++; $display("FAIL blt_neg_taken got %b want 1", taken); end
      ack();
   endtask

   task automatic test_bge_low_chunk();
      int lat;
      issue(32'h0000_00FF, 32'h0000_00FE, 3'b101, lat);
      tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL bge_latency got %0d want 5", lat); end
      tests_run++; if (lt !== 1'b0) begin tests_failed++; $display("FAIL bge_lt got %b want 0", lt); end
      tests_run++; if (eq !== 1'b0) begin tests_failed++; $display("FAIL bge_eq got %b want 0", eq); end
      tests_run++; if (taken !== 1'b1) begin tests_failed++; $display("FAIL bge_taken got %b want 1", taken); end
      ack();
   endtask

   task automatic test_hold();
      int lat;
      issue(32'h0000_0001, 32'h0000_0002, 3'b001, lat);
      tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL hold_latency got %0d want 5", lat); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         rs1d     = $urandom;
         rs2d     = $urandom;
         func     = 3'(i);
         @(posedge clk); #1;
         tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, out_valid); end
         tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
         tests_run++; if ({eq, lt, taken, illegal} !== 4'b0110) begin tests_failed++; $display("FAIL hold_result[%0d] got %b want 0110", i, {eq, lt, taken, illegal}); end
      end
      // in_valid is still high through the ack cycle; it must not be taken.
      ack();
      in_valid = 1'b0;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_after_ack_in_ready got %b want 1", in_ready); end
      repeat (3) @(posedge clk);
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_no_capture got %b want 0", out_valid); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_idle_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_illegal();
      int lat;
      issue(32'h0000_0005, 32'h0000_0005, 3'b010, lat);
      tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL ill_latency got %0d want 5", lat); end
      tests_run++; if ({eq, lt, taken, illegal} !== 4'b1001) begin tests_failed++; $display("FAIL ill_eq_result got %b want 1001", {eq, lt, taken, illegal}); end
      ack();
      // 011 must compare unsigned: 0x80000000 is larger than 1.
      issue(32'h8000_0000, 32'h0000_0001, 3'b011, lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL ill_uns_latency got %0d want 2", lat); end
      tests_run++; if ({eq, lt, taken, illegal} !== 4'b0001) begin tests_failed++; $display("FAIL ill_uns_result got %b want 0001", {eq, lt, taken, illegal}); end
      ack();
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int seen;
      in_valid = 1'b1;
      rs1d     = 32'hAAAA_5555;
      rs2d     = 32'hAAAA_5555;
      func     = 3'b000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_async_in_ready got %b want 1", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rst_abandon out_valid cycles %0d want 0", seen); end
      issue(32'h0000_0001, 32'h8000_0000, 3'b110, lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL rst_next_latency got %0d want 2", lat); end
      tests_run++; if ({eq, lt, taken, illegal} !== 4'b0110) begin tests_failed++; $display("FAIL rst_next_result got %b want 0110", {eq, lt, taken, illegal}); end
      ack();
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(32'hFFFF_FFFF, 32'h0000_0000, 3'b111, lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL b2b_first_latency got %0d want 2", lat); end
      tests_run++; if ({eq, lt, taken, illegal} !== 4'b0010) begin tests_failed++; $display("FAIL b2b_first_result got %b want 0010", {eq, lt, taken, illegal}); end
      ack();
      issue(32'h0102_0304, 32'h0102_0404, 3'b001, lat);
      tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL b2b_second_latency got %0d want 4", lat); end
      tests_run++; if ({eq, lt, taken, illegal} !== 4'b0110) begin tests_failed++; $display("FAIL b2b_second_result got %b want 0110", {eq, lt, taken, illegal}); end
      ack();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_n      = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      rs1d         = '0;
      rs2d         = '0;
      func         = '0;
      @(posedge clk); #1;
      test_reset();
      test_beq_equal();
      test_signed_unsigned();
      test_bge_low_chunk();
      test_hold();
      test_illegal();
      test_reset_mid_scan();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/chunked_comparator.md
CHUNKED_COMPARATOR -- requirements
Module: chunked_comparator

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 rs1d  in  WIDTH  operand A.
REQ-008 rs2d  in  WIDTH  operand B.
REQ-009 func  in  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 eq  out  1  A == B.
REQ-013 lt  out  1  A < B, signed if func[1]=0, else unsigned.
REQ-014 taken  out  1  branch condition per func.
REQ-015 illegal  out  1  func is 010 or 011.

Function
REQ-016 FSM states IDLE, SCAN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: in_valid=1 captures rs1d, rs2d, func into registers, sets chunk index to NCHUNK-1, moves to SCAN; in_valid=0 stays IDLE.
REQ-018 SCAN: one cycle per chunk, most-significant chunk first; index decrements by 1 per equal chunk.
REQ-019 Top chunk in signed mode: compare with sign bit of each operand inverted; all other chunks compared unsigned.
REQ-020 Chunk differs: lt = (A chunk < B chunk), eq = 0, move to DONE immediately (early exit).
REQ-021 Chunk equal and index 0: eq = 1, lt = 0, move to DONE.
REQ-022 SCAN occupancy SHALL be 1..NCHUNK cycles; input-accept to out_valid latency = scan cycles + 1.
REQ-023 taken: BEQ eq, BNE !eq, BLT/BLTU lt, BGE/BGEU !lt; illegal func -> taken=0, illegal=1, eq/lt still computed unsigned.
REQ-024 DONE: out_valid=1; eq, lt, taken, illegal registered and stable until out_ready=1.
REQ-025 DONE with out_ready=1: next cycle IDLE, out_valid=0; no input accepted in that same cycle.
REQ-026 Captured operands SHALL NOT change while in SCAN or DONE; rs1d/rs2d/func changes there are ignored.
REQ-027 WIDTH == CHUNK SHALL work (single SCAN cycle).

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, out_valid=0, eq=0, lt=0, taken=0, illegal=0, index=0, in_ready=1.
REQ-029 Reset mid-SCAN or mid-DONE abandons the request; no out_valid is ever produced for it.
REQ-030 First request after reset_n rises SHALL be accepted on the first rising edge with in_valid=1.

Structure
REQ-031 Shared package holds func encodings (BEQ..BGEU) and the state enumeration.
REQ-032 One combinational sub-module chunk_compare (CHUNK-bit inputs, signed flag; outputs eq, lt) instantiated once.
REQ-033 Chunk index counter width = clog2(NCHUNK), minimum 1.

Verification (WIDTH=32, CHUNK=8)
REQ-034 BEQ 0x12345678 vs 0x12345678 -> 4 SCAN cycles, eq=1 lt=0 taken=1 illegal=0.
REQ-035 BLT 0x80000000 vs 0x00000001 -> 1 SCAN cycle, lt=1 eq=0 taken=1; same operands BLTU -> lt=0 taken=0.
REQ-036 BGE 0x000000FF vs 0x000000FE -> 4 SCAN cycles, lt=0 eq=0 taken=1.
REQ-037 Result in DONE, out_ready=0 for 5 cycles with new in_valid and changing inputs -> outputs stable, in_ready=0, new request not captured.
REQ-038 func=010 on 0x5 vs 0x5 -> illegal=1 taken=0 eq=1.
REQ-039 reset_n low for 1 cycle during SCAN -> out_valid stays 0, in_ready=1, next request completes correctly.
